// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read RAM port between the CPU dmem path and a peripheral.
// Optional starvation guard for the peripheral is enabled by defining DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              per_req,
    input  logic              per_wren,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_data,
    output logic              per_gnt,
    output logic [DATA_W-1:0] per_q,
    output logic              per_valid,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PER  = 2'd2
    } owner_e;

    owner_e            rd_owner_r;
    logic [DATA_W-1:0] cpu_q_r;
    logic [DATA_W-1:0] per_q_r;
    logic              per_valid_r;
    logic              cpu_gnt_s;
    logic              per_gnt_s;
    logic              force_per_s;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_r;

    // Starvation counter: counts denied peripheral cycles, saturating, cleared on grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt_r <= '0;
        end else if (per_gnt_s) begin
            wait_cnt_r <= '0;
        end else if (per_req && (wait_cnt_r != WAIT_W'(MAX_WAIT))) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign force_per_s = per_req && (wait_cnt_r == WAIT_W'(MAX_WAIT));
`else
    assign force_per_s = 1'b0;
`endif

    // Grant decision: CPU first unless the peripheral has waited its limit; nothing during reset.
    always_comb begin
        cpu_gnt_s = 1'b0;
        per_gnt_s = 1'b0;
        if (!reset) begin
            cpu_gnt_s = 1'b0;
            per_gnt_s = 1'b0;
        end else if (per_req && (force_per_s || !cpu_req)) begin
            per_gnt_s = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            per_gnt_s = 1'b0;
        end
    end

    // RAM port mux: the granted requester drives the port, idle port is all zeros.
    always_comb begin
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (cpu_gnt_s) begin
            ram_wen  = cpu_wren;
            ram_addr = cpu_addr;
            ram_din  = cpu_data;
        end else if (per_gnt_s) begin
            ram_wen  = per_wren;
            ram_addr = per_addr;
            ram_din  = per_data;
        end else begin
            ram_wen  = 1'b0;
            ram_addr = '0;
            ram_din  = '0;
        end
    end

    // Read-return tracking and capture of ram_dout one cycle after the grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_owner_r  <= OWN_NONE;
            cpu_q_r     <= '0;
            per_q_r     <= '0;
            per_valid_r <= 1'b0;
        end else begin
            if (cpu_gnt_s && !cpu_wren) begin
                rd_owner_r <= OWN_CPU;
            end else if (per_gnt_s && !per_wren) begin
                rd_owner_r <= OWN_PER;
            end else begin
                rd_owner_r <= OWN_NONE;
            end
            case (rd_owner_r)
                OWN_CPU: begin
                    cpu_q_r     <= ram_dout;
                    per_q_r     <= per_q_r;
                    per_valid_r <= 1'b0;
                end
                OWN_PER: begin
                    cpu_q_r     <= cpu_q_r;
                    per_q_r     <= ram_dout;
                    per_valid_r <= 1'b1;
                end
                default: begin
                    cpu_q_r     <= cpu_q_r;
                    per_q_r     <= per_q_r;
                    per_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_gnt_s;
    assign per_gnt   = per_gnt_s;
    assign cpu_q     = cpu_q_r;
    assign per_q     = per_q_r;
    assign per_valid = per_valid_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM and a peripheral read scoreboard.
// Fairness expectations are selected by DMEM_ARB_FAIRNESS_EN to match the build of the design.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wren;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_data, cpu_q;
    logic        cpu_stall;
    logic        per_req, per_wren;
    logic [11:0] per_addr;
    logic [31:0] per_data;
    logic        per_gnt;
    logic [31:0] per_q;
    logic        per_valid;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:4095];
    logic [31:0] per_exp_q [$];
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q), .cpu_stall(cpu_stall),
        .per_req(per_req), .per_wren(per_wren), .per_addr(per_addr), .per_data(per_data),
        .per_gnt(per_gnt), .per_q(per_q), .per_valid(per_valid),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // Behavioural RAM with one-cycle synchronous read.
    always @(posedge clock) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every per_valid pulse must match the oldest expected peripheral read.
    always @(negedge clock) begin
        if (per_valid === 1'b1) begin
            if (per_exp_q.size() == 0) begin
                chk("per_valid_unexpected", 32'(per_valid), 32'd0);
            end else begin
                chk("per_q_scoreboard", per_q, per_exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_data = 32'h5;
        per_req = 1'b1; per_wren = 1'b0; per_addr = 12'h020; per_data = 32'h0;

        // Reset held 3 cycles with both requesters active
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
            chk("rst_per_gnt", 32'(per_gnt), 32'd0);
            chk("rst_per_valid", 32'(per_valid), 32'd0);
            chk("rst_ram_wen", 32'(ram_wen), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_ram_din", ram_din, 32'd0);
            chk("rst_cpu_q", cpu_q, 32'd0);
            chk("rst_per_q", per_q, 32'd0);
        end

        // CPU write 0x5 -> 0x010
        tick();
        reset = 1'b1; per_req = 1'b0;
        settle();
        chk("cw_ram_wen", 32'(ram_wen), 32'd1);
        chk("cw_ram_addr", 32'(ram_addr), 32'h010);
        chk("cw_ram_din", ram_din, 32'h5);
        chk("cw_cpu_stall", 32'(cpu_stall), 32'd0);

        // Peripheral read of 0x010 with CPU idle
        tick();
        cpu_req = 1'b0; per_req = 1'b1; per_wren = 1'b0; per_addr = 12'h010;
        settle();
        chk("pr_per_gnt", 32'(per_gnt), 32'd1);
        chk("pr_ram_wen", 32'(ram_wen), 32'd0);
        chk("pr_ram_addr", 32'(ram_addr), 32'h010);
        per_exp_q.push_back(32'h5);
        tick();
        per_req = 1'b0;
        settle();
        chk("pr_valid_n1", 32'(per_valid), 32'd0);
        chk("pr_idle_ram_addr", 32'(ram_addr), 32'd0);
        tick(); settle();
        chk("pr_valid_n2", 32'(per_valid), 32'd1);
        chk("pr_q_n2", per_q, 32'h5);
        tick(); settle();
        chk("pr_valid_n3", 32'(per_valid), 32'd0);

        // Both requesting continuously (CPU reads 0x010, peripheral reads 0x010)
        tick();
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h010;
        per_req = 1'b1; per_wren = 1'b0; per_addr = 12'h010;
`ifdef DMEM_ARB_FAIRNESS_EN
        for (int i = 1; i <= 8; i++) begin
            settle();
            chk("fair_wait_per_gnt", 32'(per_gnt), 32'd0);
            chk("fair_wait_stall", 32'(cpu_stall), 32'd0);
            tick();
        end
        settle();
        chk("fair_9th_per_gnt", 32'(per_gnt), 32'd1);
        chk("fair_9th_stall", 32'(cpu_stall), 32'd1);
        per_exp_q.push_back(32'h5);
        tick();
        per_req = 1'b0;
        settle();
        chk("fair_after_stall", 32'(cpu_stall), 32'd0);
        chk("fair_after_ram_addr", 32'(ram_addr), 32'h010);
        tick();
        cpu_req = 1'b0;
        tick(); tick();
        settle();
`else
        for (int i = 0; i < 12; i++) begin
            settle();
            chk("prio_per_gnt", 32'(per_gnt), 32'd0);
            chk("prio_cpu_stall", 32'(cpu_stall), 32'd0);
            tick();
        end
        cpu_req = 1'b0;
        settle();
        chk("prio_release_per_gnt", 32'(per_gnt), 32'd1);
        per_exp_q.push_back(32'h5);
        tick();
        per_req = 1'b0;
        tick(); tick();
        settle();
`endif
        chk("cpu_q_after_contention", cpu_q, 32'h5);

        // Setup: CPU writes 0x1234 -> 0xA, peripheral writes 0x9 -> 0xB
        tick();
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h00A; cpu_data = 32'h1234;
        tick();
        cpu_req = 1'b0;
        per_req = 1'b1; per_wren = 1'b1; per_addr = 12'h00B; per_data = 32'h9;
        settle();
        chk("pw_per_gnt", 32'(per_gnt), 32'd1);
        chk("pw_ram_wen", 32'(ram_wen), 32'd1);
        chk("pw_ram_din", ram_din, 32'h9);

        // CPU read 0xA then peripheral read 0xB on consecutive cycles
        tick();
        per_req = 1'b0;
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h00A;
        settle();
        chk("cr_ram_addr", 32'(ram_addr), 32'h00A);
        chk("cr_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_req = 1'b0;
        per_req = 1'b1; per_wren = 1'b0; per_addr = 12'h00B;
        settle();
        chk("pr2_per_gnt", 32'(per_gnt), 32'd1);
        chk("cr_q_n1", cpu_q, 32'h5);
        per_exp_q.push_back(32'h9);
        tick();
        per_req = 1'b0;
        settle();
        chk("cr_q_n2", cpu_q, 32'h1234);
        tick(); settle();
        chk("pr2_valid", 32'(per_valid), 32'd1);
        chk("cr_q_hold1", cpu_q, 32'h1234);
        tick(); tick(); settle();
        chk("cr_q_hold2", cpu_q, 32'h1234);
        chk("pr2_q_hold", per_q, 32'h9);

        // Peripheral read granted, then reset asserted the following cycle
        tick();
        per_req = 1'b1; per_wren = 1'b0; per_addr = 12'h00A;
        settle();
        chk("rr_per_gnt", 32'(per_gnt), 32'd1);
        tick();
        reset = 1'b0; per_req = 1'b0;
        settle();
        chk("rr_valid_n1", 32'(per_valid), 32'd0);
        tick(); settle();
        chk("rr_valid_n2", 32'(per_valid), 32'd0);
        chk("rr_per_q", per_q, 32'd0);
        chk("rr_cpu_q", cpu_q, 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick(); settle();
        chk("rr_valid_after", 32'(per_valid), 32'd0);
        chk("scoreboard_drained", 32'(per_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
